pd_gpio_sequencer: RTL and testbench

PD_GPIO_SEQUENCER -- requirements
Module: pd_gpio_sequencer

---
 rtl/pd_gpio_seq_pkg.sv | 59 +++++
 rtl/pd_gpio_seq_timer.sv | 54 +++++
 rtl/pd_gpio_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pd_gpio_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_gpio_seq_pkg.sv
// Shared types and constants for the GPIO (PIO) command sequencer:
// command opcodes, FSM states, PIO register map and the bus-cycle bundle.
package pd_gpio_seq_pkg;

  // Command opcodes as presented on cmd_op.
  typedef enum logic [1:0] {
    OP_WRITE     = 2'd0,
    OP_SET       = 2'd1,
    OP_CLEAR     = 2'd2,
    OP_WAIT_EDGE = 2'd3
  } op_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_RDW  = 3'd3,
    ST_GAP  = 3'd4,
    ST_CLR  = 3'd5,
    ST_RSP  = 3'd6
  } state_e;

  // PIO register map.
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  // Writing all ones to the edge-capture register clears every capture bit.
  localparam logic [31:0] EDGE_CLEAR_ALL = 32'hFFFF_FFFF;

  // One bus cycle worth of master-side signals.
  typedef struct packed {
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
  } avm_cmd_t;

  localparam avm_cmd_t AVM_IDLE = '{
    address:    3'd0,
    chipselect: 1'b0,
    write_n:    1'b1,
    writedata:  32'd0
  };

  // Register targeted by a write-type command.
  function automatic logic [2:0] op_addr(input op_e op);
    logic [2:0] addr;
    unique case (op)
      OP_SET:   addr = ADDR_SET;
      OP_CLEAR: addr = ADDR_CLR;
      default:  addr = ADDR_DATA;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/pd_gpio_seq_timer.sv
// Counters for the sequencer: a saturating elapsed-cycle counter for the
// WAIT_EDGE timeout and a poll-gap counter that paces edge-capture reads.
module pd_gpio_seq_timer
  import pd_gpio_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int POLL_GAP       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,            // zero the elapsed counter (command accepted)
  input  logic tick,             // advance the elapsed counter this cycle
  input  logic gap_run,          // sequencer is sitting in the poll gap
  output logic gap_expired,      // current cycle is the last gap cycle
  output logic timeout_expired   // elapsed has reached TIMEOUT_CYCLES
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  localparam logic [TW-1:0] T_LIMIT  = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  logic [TW-1:0] elapsed;
  logic [GW-1:0] gap_cnt;

  // Elapsed counter: cleared on acceptance, counts up and sticks at the limit.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      elapsed <= '0;
    end else if (start) begin
      elapsed <= '0;
    end else if (tick && (elapsed != T_LIMIT)) begin
      elapsed <= elapsed + TW'(1);
    end
  end

  // Gap counter: runs only while in the gap, self-clears on its last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (gap_run && !gap_expired) begin
      gap_cnt <= gap_cnt + GW'(1);
    end else begin
      gap_cnt <= '0;
    end
  end

  assign gap_expired     = gap_run && (gap_cnt == GAP_LAST);
  assign timeout_expired = (elapsed >= T_LIMIT);

endmodule

// File: rtl/pd_gpio_sequencer.sv
// Command sequencer for an Avalon-MM PIO: turns WRITE/SET/CLEAR commands
// into single register writes and WAIT_EDGE into a paced poll of the
// edge-capture register, clearing captures on a hit or timing out.
module pd_gpio_sequencer
  import pd_gpio_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int POLL_GAP       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        rsp_valid,
  output logic        rsp_timeout,
  output logic [31:0] rsp_edges,
  output logic        busy
);

  state_e      state;
  state_e      state_next;
  op_e         op_q;
  logic [31:0] data_q;         // write value or WAIT_EDGE mask
  logic [31:0] edge_q;         // edge-capture value sampled in RDW
  logic [31:0] rsp_edges_q;
  logic        rsp_timeout_q;
  avm_cmd_t    bus;

  logic accept;
  logic edge_hit;
  logic gap_expired;
  logic timeout_expired;

  assign accept   = cmd_valid && (state == ST_IDLE);
  assign edge_hit = (avm_readdata & data_q) != 32'd0;

  pd_gpio_seq_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .POLL_GAP       (POLL_GAP)
  ) u_timer (
    .clk             (clk),
    .reset           (reset),
    .start           (accept),
    .tick            (state != ST_IDLE),
    .gap_run         (state == ST_GAP),
    .gap_expired     (gap_expired),
    .timeout_expired (timeout_expired)
  );

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A hit wins over a timeout reached in the same RDW cycle.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_e'(cmd_op) == OP_WAIT_EDGE) begin
            state_next = (cmd_data == 32'd0) ? ST_RSP : ST_RD;
          end else begin
            state_next = ST_WR;
          end
        end
      end
      ST_WR:  state_next = ST_RSP;
      ST_RD:  state_next = ST_RDW;
      ST_RDW: begin
        if (edge_hit) begin
          state_next = ST_CLR;
        end else if (timeout_expired) begin
          state_next = ST_RSP;
        end else begin
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_expired) begin
          state_next = ST_RD;
        end
      end
      ST_CLR:  state_next = ST_RSP;
      ST_RSP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Command latch and edge-capture sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_WRITE;
      data_q <= '0;
      edge_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        data_q <= cmd_data;
      end
      if (state == ST_RDW) begin
        edge_q <= avm_readdata;
      end
    end
  end

  // Response fields: loaded on the way into RSP and held until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_timeout_q <= 1'b0;
      rsp_edges_q   <= '0;
    end else if ((state_next == ST_RSP) && (state != ST_RSP)) begin
      // Only the RDW->RSP path is a timeout; only CLR->RSP carries edges.
      rsp_timeout_q <= (state == ST_RDW);
      rsp_edges_q   <= (state == ST_CLR) ? edge_q : 32'd0;
    end
  end

  // Bus cycle driven in the current state; idle bus everywhere else.
  always_comb begin
    bus = AVM_IDLE;
    unique case (state)
      ST_WR: begin
        bus.address    = op_addr(op_q);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = data_q;
      end
      ST_RD: begin
        bus.address    = ADDR_EDGE;
        bus.chipselect = 1'b1;
      end
      ST_CLR: begin
        bus.address    = ADDR_EDGE;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = EDGE_CLEAR_ALL;
      end
      default: bus = AVM_IDLE;
    endcase
  end

  assign avm_address    = bus.address;
  assign avm_chipselect = bus.chipselect;
  assign avm_write_n    = bus.write_n;
  assign avm_writedata  = bus.writedata;

  assign cmd_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign rsp_valid   = (state == ST_RSP);
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_edges   = rsp_edges_q;

endmodule

// File: tb/tb_pd_gpio_sequencer.sv
// Directed bench for pd_gpio_sequencer with a scoreboard of expected bus
// writes and responses and a small PIO edge-capture read model.
module tb_pd_gpio_sequencer;
  import pd_gpio_seq_pkg::*;

  localparam int TIMEOUT = 20;
  localparam int GAP     = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_timeout;
  logic [31:0] rsp_edges;
  logic        busy;

  pd_gpio_sequencer #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .POLL_GAP       (GAP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .rsp_valid      (rsp_valid),
    .rsp_timeout    (rsp_timeout),
    .rsp_edges      (rsp_edges),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        timeout;
    logic [31:0] edges;
    int          lat_lo;
    int          lat_hi;
  } rsp_exp_t;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  rsp_exp_t rsp_q[$];
  wr_exp_t  wr_q[$];
  rsp_exp_t r;
  wr_exp_t  w;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int accept_cyc = 0;
  int last_rd_cyc = -1;
  int read_count = 0;
  int model_base = 0;
  int model_zero_polls = 0;
  logic [31:0] model_value = 32'd0;
  logic rd_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, read-data model and scoreboard, all sampled mid-cycle.
  always @(negedge clk) begin
    // PIO returns read data one cycle after the read cycle.
    if (rd_pending) begin
      read_count++;
      avm_readdata = ((read_count - model_base) > model_zero_polls) ? model_value : 32'd0;
    end else begin
      avm_readdata = 32'd0;
    end
    rd_pending = avm_chipselect && avm_write_n && (avm_address == ADDR_EDGE);

    if (cmd_valid && cmd_ready && !reset) begin
      accept_cyc  = cyc;
      last_rd_cyc = -1;
    end

    if (avm_chipselect && avm_write_n && (avm_address == ADDR_EDGE)) begin
      if (last_rd_cyc >= 0) check("poll_spacing", 32'(cyc - last_rd_cyc), 32'(GAP + 2));
      last_rd_cyc = cyc;
    end

    if (avm_chipselect && !avm_write_n) begin
      check("write_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        check("write_addr", 32'(avm_address), 32'(w.addr));
        check("write_data", avm_writedata, w.data);
      end
    end

    if (rsp_valid) begin
      check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        check("rsp_timeout", 32'(rsp_timeout), 32'(r.timeout));
        check("rsp_edges", rsp_edges, r.edges);
        check_range("rsp_latency", cyc - accept_cyc, r.lat_lo, r.lat_hi);
      end
    end
  end

  task automatic issue(input op_e op, input logic [31:0] data);
    @(posedge clk);
    #1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (((rsp_q.size() != 0) || !cmd_ready) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_drained"}, 32'(rsp_q.size()), 32'd0);
    check({tag, "_wr_drained"}, 32'(wr_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_cs"}, 32'(avm_chipselect), 32'd0);
    check({tag, "_write_n"}, 32'(avm_write_n), 32'd1);
    check({tag, "_addr"}, 32'(avm_address), 32'd0);
    check({tag, "_wdata"}, avm_writedata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic cs_any;
    logic rsp_any;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("reset_rsp_edges", rsp_edges, 32'd0);

    // WRITE: bus write in the cycle after acceptance, response one later.
    wr_q.push_back('{addr: ADDR_DATA, data: 32'hA5A5_0001});
    rsp_q.push_back('{timeout: 1'b0, edges: 32'd0, lat_lo: 2, lat_hi: 2});
    issue(OP_WRITE, 32'hA5A5_0001);
    @(negedge clk) check("wr_ready_n1", 32'(cmd_ready), 32'd0);
    @(negedge clk) check("wr_ready_n2", 32'(cmd_ready), 32'd0);
    @(negedge clk) check("wr_ready_n3", 32'(cmd_ready), 32'd1);
    drain("write", 20);

    // SET then CLEAR.
    wr_q.push_back('{addr: ADDR_SET, data: 32'h0000_0010});
    rsp_q.push_back('{timeout: 1'b0, edges: 32'd0, lat_lo: 2, lat_hi: 2});
    issue(OP_SET, 32'h0000_0010);
    drain("set", 20);
    wr_q.push_back('{addr: ADDR_CLR, data: 32'h0000_0001});
    rsp_q.push_back('{timeout: 1'b0, edges: 32'd0, lat_lo: 2, lat_hi: 2});
    issue(OP_CLEAR, 32'h0000_0001);
    drain("clear", 20);

    // WAIT_EDGE with an empty mask: immediate response, no bus activity.
    rsp_q.push_back('{timeout: 1'b0, edges: 32'd0, lat_lo: 1, lat_hi: 2});
    cs_any = 1'b0;
    issue(OP_WAIT_EDGE, 32'd0);
    repeat (6) begin
      @(negedge clk);
      cs_any |= avm_chipselect;
    end
    check("mask0_no_cs", 32'(cs_any), 32'd0);
    drain("mask0", 20);

    // WAIT_EDGE timeout: polls at elapsed 1,7,13,19,25 -> five reads, response
    // 27 cycles after acceptance, no clear write. A WRITE offered while busy
    // must be dropped.
    model_base       = read_count;
    model_zero_polls = 1000;
    model_value      = 32'h0000_0001;
    rsp_q.push_back('{timeout: 1'b1, edges: 32'd0, lat_lo: 27, lat_hi: 27});
    issue(OP_WAIT_EDGE, 32'h0000_0001);
    @(posedge clk);
    #1;
    cmd_op    = OP_WRITE;
    cmd_data  = 32'hDEAD_BEEF;
    cmd_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 cmd_valid = 1'b0;
    drain("timeout", 100);
    check("timeout_reads", 32'(read_count - model_base), 32'd5);
    repeat (3) @(negedge clk);
    check("timeout_hold_flag", 32'(rsp_timeout), 32'd1);
    check("timeout_hold_edges", rsp_edges, 32'd0);

    // WAIT_EDGE match on the fourth poll (elapsed 19 < 20): clear write,
    // edges reported unmasked, response 22 cycles after acceptance.
    model_base       = read_count;
    model_zero_polls = 3;
    model_value      = 32'h0000_0006;
    wr_q.push_back('{addr: ADDR_EDGE, data: 32'hFFFF_FFFF});
    rsp_q.push_back('{timeout: 1'b0, edges: 32'h0000_0006, lat_lo: 22, lat_hi: 22});
    issue(OP_WAIT_EDGE, 32'h0000_0004);
    drain("edge", 100);
    check("edge_reads", 32'(read_count - model_base), 32'd4);
    repeat (3) @(negedge clk);
    check("edge_hold_edges", rsp_edges, 32'h0000_0006);
    check("edge_hold_flag", 32'(rsp_timeout), 32'd0);

    // Reset during the poll gap: abort with no response and no bus cycles.
    model_base       = read_count;
    model_zero_polls = 1000;
    issue(OP_WAIT_EDGE, 32'h0000_0001);
    @(negedge clk);   // RD
    @(negedge clk);   // RDW
    @(negedge clk);   // first GAP cycle
    check("gap_before_reset_cs", 32'(avm_chipselect), 32'd0);
    check("gap_before_reset_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    check("post_reset_rsp_edges", rsp_edges, 32'd0);
    cs_any  = 1'b0;
    rsp_any = 1'b0;
    repeat (40) begin
      @(negedge clk);
      cs_any  |= avm_chipselect;
      rsp_any |= rsp_valid;
    end
    check("post_reset_no_cs", 32'(cs_any), 32'd0);
    check("post_reset_no_rsp", 32'(rsp_any), 32'd0);
    check("post_reset_q_empty", 32'(rsp_q.size() + wr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
